inst_fifo: RTL

INST_FIFO -- requirements
Module: inst_fifo

---
 rtl/inst_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inst_fifo.sv
`default_nettype none
// inst_fifo: dual-push / dual-pop circular instruction queue between fetch and decode.
// Optional same-cycle forwarding into an empty queue: define INST_FIFO_BYPASS_EN.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_pc1,
    input  logic [31:0] write_pc2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic        read_valid1,
    output logic        read_valid2,
    output logic [31:0] read_pc1,
    output logic [31:0] read_pc2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic        empty,
    output logic        almost_empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_ONE      = (AW+1)'(1);
    localparam logic [AW:0] C_DEPTH_M1 = (AW+1)'(DEPTH - 1);

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW-1:0] rptr_p1, wptr_p1;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    push_n, pop_req, pop_n, mem_pop, store_n;
    logic          byp_act, skip_slot1;
    logic          wr0_en, wr1_en;
    logic [31:0]   wr0_pc, wr0_inst;

    assign rptr_p1 = rptr_q + AW'(1);
    assign wptr_p1 = wptr_q + AW'(1);

    always_comb begin
        full    = (count_q >= C_DEPTH_M1);
        push_n  = (write_en1 && !full) ? (write_en2 ? 2'd2 : 2'd1) : 2'd0;
        pop_req = read_en1 ? (read_en2 ? 2'd2 : 2'd1) : 2'd0;
`ifdef INST_FIFO_BYPASS_EN
        byp_act = (count_q == '0);
`else
        byp_act = 1'b0;
`endif
        // With forwarding active, pops are served from the incoming slots and only the rest is stored
        if (byp_act) begin
            pop_n      = (pop_req < push_n) ? pop_req : push_n;
            store_n    = push_n - pop_n;
            skip_slot1 = (pop_n == 2'd1);
            mem_pop    = 2'd0;
        end else begin
            if (count_q == '0)
                pop_n = 2'd0;
            else if (count_q == C_ONE && pop_req == 2'd2)
                pop_n = 2'd1;
            else
                pop_n = pop_req;
            store_n    = push_n;
            skip_slot1 = 1'b0;
            mem_pop    = pop_n;
        end

        wr0_en   = !flush && (store_n != 2'd0);
        wr1_en   = !flush && (store_n == 2'd2);
        wr0_pc   = skip_slot1 ? write_pc2   : write_pc1;
        wr0_inst = skip_slot1 ? write_inst2 : write_inst1;

        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            rptr_d  = rptr_q + AW'(mem_pop);
            wptr_d  = wptr_q + AW'(store_n);
            count_d = count_q + (AW+1)'(store_n) - (AW+1)'(mem_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            pc_mem_q[wptr_q]   <= wr0_pc;
            inst_mem_q[wptr_q] <= wr0_inst;
        end
        if (wr1_en) begin
            pc_mem_q[wptr_p1]   <= write_pc2;
            inst_mem_q[wptr_p1] <= write_inst2;
        end
    end

    always_comb begin
        empty        = (count_q == '0);
        almost_empty = (count_q == C_ONE);
        read_valid1  = (count_q != '0);
        read_valid2  = (count_q > C_ONE);
        read_pc1     = read_valid1 ? pc_mem_q[rptr_q]    : 32'h0;
        read_inst1   = read_valid1 ? inst_mem_q[rptr_q]  : 32'h0;
        read_pc2     = read_valid2 ? pc_mem_q[rptr_p1]   : 32'h0;
        read_inst2   = read_valid2 ? inst_mem_q[rptr_p1] : 32'h0;
`ifdef INST_FIFO_BYPASS_EN
        if (count_q == '0 && !flush) begin
            read_valid1 = write_en1;
            read_valid2 = write_en1 & write_en2;
            read_pc1    = read_valid1 ? write_pc1   : 32'h0;
            read_inst1  = read_valid1 ? write_inst1 : 32'h0;
            read_pc2    = read_valid2 ? write_pc2   : 32'h0;
            read_inst2  = read_valid2 ? write_inst2 : 32'h0;
        end
`endif
    end
endmodule
`default_nettype wire
